ps2_move_decoder: RTL and testbench

Converts the raw PS/2 byte stream from `PS2_Controller` into single, de-duplicated player-move requests and a start-key pulse for the game handshake FSM. It sits directly between the keyboard controller (`received_data`/`received_data_en`) and the FSM's movement input. It replaces per-byte scancode matching inside the FSM with a registered valid/ready move channel.

---
 rtl/ps2_move_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ps2_move_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_move_decoder.sv
// PS/2 scancode stream to de-duplicated player-move requests and a start pulse.
// It drives a single-entry valid/ready move buffer that feeds the game handshake FSM.
module ps2_move_decoder #(
    parameter bit REPEAT_ENABLE = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       start_pulse,
    output logic       overrun,
    output logic [3:0] held
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    state_e     state_q, state_d;
    logic       move_valid_q, move_valid_d;
    logic [1:0] move_dir_q, move_dir_d;
    logic       start_pulse_q, start_pulse_d;
    logic       overrun_q, overrun_d;
    logic [3:0] held_q, held_d;
    logic       space_held_q, space_held_d;

    logic       is_make;
    logic       is_break;
    logic       is_ext;
    logic       dir_hit;
    dir_e       dir_code;
    logic       space_hit;
    logic       new_move;

    // Prefix tracking: classify the current byte as make/release, normal/extended.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        is_ext   = 1'b0;
        if (ps2_key_pressed) begin
            unique case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == CODE_EXT) begin
                        state_d = S_EXT;
                    end else if (ps2_key_data == CODE_BRK) begin
                        state_d = S_BRK;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_key_data == CODE_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if (ps2_key_data == CODE_EXT) begin
                        state_d = S_EXT;
                    end else begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    is_break = 1'b1;
                    state_d  = S_IDLE;
                end
                S_EXT_BRK: begin
                    is_break = 1'b1;
                    is_ext   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Key map: WASD on the normal page, arrow keys on the extended page.
    always_comb begin
        dir_hit  = 1'b1;
        dir_code = DIR_UP;
        if (is_ext) begin
            unique case (ps2_key_data)
                8'h75:   dir_code = DIR_UP;
                8'h72:   dir_code = DIR_DOWN;
                8'h6B:   dir_code = DIR_LEFT;
                8'h74:   dir_code = DIR_RIGHT;
                default: dir_hit  = 1'b0;
            endcase
        end else begin
            unique case (ps2_key_data)
                8'h1D:   dir_code = DIR_UP;
                8'h1B:   dir_code = DIR_DOWN;
                8'h1C:   dir_code = DIR_LEFT;
                8'h23:   dir_code = DIR_RIGHT;
                default: dir_hit  = 1'b0;
            endcase
        end
        space_hit = !is_ext && (ps2_key_data == CODE_SPACE);
    end

    // Held flags, repeat suppression and the one-entry move buffer.
    always_comb begin
        held_d        = held_q;
        space_held_d  = space_held_q;
        start_pulse_d = 1'b0;
        move_valid_d  = move_valid_q;
        move_dir_d    = move_dir_q;
        overrun_d     = overrun_q;
        new_move      = 1'b0;

        if (dir_hit && is_make) begin
            new_move         = REPEAT_ENABLE || !held_q[dir_code];
            held_d[dir_code] = 1'b1;
        end
        if (dir_hit && is_break) begin
            held_d[dir_code] = 1'b0;
        end

        if (space_hit && is_make) begin
            start_pulse_d = REPEAT_ENABLE || !space_held_q;
            space_held_d  = 1'b1;
        end
        if (space_hit && is_break) begin
            space_held_d = 1'b0;
        end

        if (new_move) begin
            move_dir_d   = dir_code;
            move_valid_d = 1'b1;
            if (move_valid_q && !move_ready) begin
                overrun_d = 1'b1;
            end
        end else if (move_valid_q && move_ready) begin
            move_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            move_valid_q  <= 1'b0;
            move_dir_q    <= 2'b00;
            start_pulse_q <= 1'b0;
            overrun_q     <= 1'b0;
            held_q        <= 4'b0000;
            space_held_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            move_valid_q  <= move_valid_d;
            move_dir_q    <= move_dir_d;
            start_pulse_q <= start_pulse_d;
            overrun_q     <= overrun_d;
            held_q        <= held_d;
            space_held_q  <= space_held_d;
        end
    end

    assign move_valid  = move_valid_q;
    assign move_dir    = move_dir_q;
    assign start_pulse = start_pulse_q;
    assign overrun     = overrun_q;
    assign held        = held_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: one instance without and one with typematic repeat.
module tb_ps2_move_decoder;

    logic       clk;
    logic       resetn;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       move_ready;

    logic       mv0, sp0, ov0;
    logic [1:0] dir0;
    logic [3:0] held0;
    logic       mv1, sp1, ov1;
    logic [1:0] dir1;
    logic [3:0] held1;

    int chk_cnt;
    int pass_cnt;
    int n0, n1, s0, s1;

    ps2_move_decoder #(.REPEAT_ENABLE(1'b0)) u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .move_ready      (move_ready),
        .move_valid      (mv0),
        .move_dir        (dir0),
        .start_pulse     (sp0),
        .overrun         (ov0),
        .held            (held0)
    );

    ps2_move_decoder #(.REPEAT_ENABLE(1'b1)) u_dut_rep (
        .clk             (clk),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .move_ready      (move_ready),
        .move_valid      (mv1),
        .move_dir        (dir1),
        .start_pulse     (sp1),
        .overrun         (ov1),
        .held            (held1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally transfers and pulses as seen just before the edge, then advance one cycle.
    task automatic cyc();
        if (mv0 && move_ready) n0++;
        if (mv1 && move_ready) n1++;
        if (sp0) s0++;
        if (sp1) s1++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        cyc();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic clear_counts();
        n0 = 0; n1 = 0; s0 = 0; s1 = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        chk_cnt++;
        if ({mv0, dir0, sp0, ov0, held0} !== 9'b0) $display("FAIL reset_outputs: got %b required 000000000", {mv0, dir0, sp0, ov0, held0});
        else pass_cnt++;
        chk_cnt++;
        if ({mv1, dir1, sp1, ov1, held1} !== 9'b0) $display("FAIL reset_outputs_rep: got %b required 000000000", {mv1, dir1, sp1, ov1, held1});
        else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_buffer_hold();
        int hold_bad;
        move_ready = 1'b0;
        send(8'h1D);
        chk_cnt++;
        if ({mv0, dir0} !== 3'b1_00) $display("FAIL load_up: got valid/dir %b required 100", {mv0, dir0});
        else pass_cnt++;
        chk_cnt++;
        if (held0 !== 4'b0001) $display("FAIL held_up: got %b required 0001", held0);
        else pass_cnt++;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if ({mv0, dir0} !== 3'b1_00) hold_bad++;
        end
        chk_cnt++;
        if (hold_bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles required 0", hold_bad);
        else pass_cnt++;
        move_ready = 1'b1;
        cyc();
        move_ready = 1'b0;
        chk_cnt++;
        if (mv0 !== 1'b0) $display("FAIL accept_clear: got valid %b required 0", mv0);
        else pass_cnt++;
        send(8'hF0);
        send(8'h1D);
        chk_cnt++;
        if (held0 !== 4'b0000) $display("FAIL release_up: got %b required 0000", held0);
        else pass_cnt++;
    endtask

    task automatic test_ext_make();
        move_ready = 1'b1;
        clear_counts();
        send(8'hE0);
        chk_cnt++;
        if (mv0 !== 1'b0) $display("FAIL prefix_no_move: got valid %b required 0", mv0);
        else pass_cnt++;
        send(8'h74);
        chk_cnt++;
        if ({mv0, dir0, held0} !== 7'b1_11_1000) $display("FAIL ext_right: got %b required 1111000", {mv0, dir0, held0});
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if (mv0 !== 1'b0 || n0 !== 1) $display("FAIL ext_right_once: got valid %b transfers %0d required 0 and 1", mv0, n0);
        else pass_cnt++;
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        cyc();
        chk_cnt++;
        if (held0 !== 4'b0000 || mv0 !== 1'b0 || n0 !== 1) $display("FAIL ext_release: got held %b valid %b transfers %0d required 0000 0 1", held0, mv0, n0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_repeat();
        move_ready = 1'b1;
        clear_counts();
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'h1C);
        cyc();
        cyc();
        chk_cnt++;
        if (n0 !== 2) $display("FAIL repeat_off_moves: got %0d required 2", n0);
        else pass_cnt++;
        chk_cnt++;
        if (n1 !== 4) $display("FAIL repeat_on_moves: got %0d required 4", n1);
        else pass_cnt++;
        chk_cnt++;
        if (dir0 !== 2'b10 || held0 !== 4'b0100) $display("FAIL repeat_dir_held: got dir %b held %b required 10 0100", dir0, held0);
        else pass_cnt++;
        send(8'hF0);
        send(8'h1C);
        chk_cnt++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) $display("FAIL no_overrun_when_ready: got %b%b required 00", ov0, ov1);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        move_ready = 1'b0;
        send(8'h1B);
        send(8'h23);
        chk_cnt++;
        if ({mv0, dir0, ov0} !== 4'b1_11_1) $display("FAIL overrun_newest: got valid/dir/ovr %b required 1111", {mv0, dir0, ov0});
        else pass_cnt++;
        chk_cnt++;
        if (held0 !== 4'b1010) $display("FAIL overrun_held: got %b required 1010", held0);
        else pass_cnt++;
        move_ready = 1'b1;
        cyc();
        cyc();
        chk_cnt++;
        if (ov0 !== 1'b1 || mv0 !== 1'b0) $display("FAIL overrun_sticky: got ovr %b valid %b required 1 0", ov0, mv0);
        else pass_cnt++;
        move_ready = 1'b0;
        test_reset();
        chk_cnt++;
        if (ov0 !== 1'b0 || held0 !== 4'b0000) $display("FAIL overrun_reset: got ovr %b held %b required 0 0000", ov0, held0);
        else pass_cnt++;
    endtask

    task automatic test_start();
        move_ready = 1'b0;
        clear_counts();
        send(8'h29);
        chk_cnt++;
        if (sp0 !== 1'b1 || mv0 !== 1'b0) $display("FAIL start_pulse: got pulse %b valid %b required 1 0", sp0, mv0);
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if (sp0 !== 1'b0) $display("FAIL start_one_cycle: got %b required 0", sp0);
        else pass_cnt++;
        send(8'h29);
        send(8'hE0);
        send(8'h29);
        send(8'hF0);
        send(8'h29);
        cyc();
        chk_cnt++;
        if (s0 !== 1 || s1 !== 2) $display("FAIL start_filter: got pulses %0d/%0d required 1/2", s0, s1);
        else pass_cnt++;
        send(8'h29);
        cyc();
        chk_cnt++;
        if (s0 !== 2 || s1 !== 3 || mv0 !== 1'b0) $display("FAIL start_after_release: got pulses %0d/%0d valid %b required 2/3 0", s0, s1, mv0);
        else pass_cnt++;
        send(8'hF0);
        send(8'h29);
    endtask

    task automatic test_abort();
        move_ready = 1'b0;
        send(8'hE0);
        #2;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        send(8'h75);
        cyc();
        chk_cnt++;
        if (mv0 !== 1'b0 || held0 !== 4'b0000) $display("FAIL abort_prefix: got valid %b held %b required 0 0000", mv0, held0);
        else pass_cnt++;
        send(8'h12);
        send(8'hE0);
        send(8'hF0);
        send(8'h11);
        cyc();
        chk_cnt++;
        if ({mv0, dir0, sp0, ov0, held0} !== 9'b0) $display("FAIL unmapped_ignored: got %b required 000000000", {mv0, dir0, sp0, ov0, held0});
        else pass_cnt++;
        send(8'h1D);
        chk_cnt++;
        if ({mv0, dir0, held0} !== 7'b1_00_0001) $display("FAIL back_in_idle: got %b required 1000001", {mv0, dir0, held0});
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt         = 0;
        pass_cnt        = 0;
        resetn          = 1'b0;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        move_ready      = 1'b0;
        clear_counts();
        test_reset();
        test_buffer_hold();
        test_ext_make();
        test_back_to_back_repeat();
        test_overrun();
        test_start();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
